// File: rtl/echo_pipe_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : echo_pipe_deserializer_if
// Description : Beat-side and pipe-side handshake bundle for the
//               echo_pipe_deserializer.
//               beat_enq__ENA / beat_enq_v / beat_enq__RDY : 32-bit beat input
//               pipe_enq__ENA / pipe_enq_v / pipe_enq__RDY : 96-bit msg output
//               slave  : view of the deserializer itself
//               master : view of the environment (beat source, pipe sink)
// Revision    : 1.0 - initial release
// ============================================================================
interface echo_pipe_deserializer_if;
    logic        beat_enq__ENA;
    logic [31:0] beat_enq_v;
    logic        beat_enq__RDY;
    logic        pipe_enq__ENA;
    logic [95:0] pipe_enq_v;
    logic        pipe_enq__RDY;

    modport slave (
        input  beat_enq__ENA,
        input  beat_enq_v,
        output beat_enq__RDY,
        output pipe_enq__ENA,
        output pipe_enq_v,
        input  pipe_enq__RDY
    );

    modport master (
        output beat_enq__ENA,
        output beat_enq_v,
        input  beat_enq__RDY,
        input  pipe_enq__ENA,
        input  pipe_enq_v,
        output pipe_enq__RDY
    );
endinterface
`default_nettype wire

// File: rtl/echo_pipe_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : echo_pipe_deserializer
// Description : Receive end of the 96-bit pipe serializer. Reassembles 3-beat
//               frames (tag, meth, v) into {v, meth, tag} messages, drops
//               frames with an out-of-range tag and counts them, and buffers
//               up to two assembled messages in a small FIFO.
// Ports       : CLK       - clock
//               nRST      - asynchronous active-high reset
//               bus       - beat input / pipe output handshakes (slave)
//               err_count - saturating count of dropped frames
// Revision    : 1.0 - initial release
// ============================================================================
module echo_pipe_deserializer #(
    parameter int unsigned MAX_TAG = 1,
    parameter int unsigned ERR_W   = 8
) (
    input  wire logic                CLK,
    input  wire logic                nRST,
    echo_pipe_deserializer_if.slave  bus,
    output logic [ERR_W-1:0]         err_count
);

    typedef enum logic [1:0] {
        S_TAG  = 2'd0,
        S_METH = 2'd1,
        S_V    = 2'd2
    } state_t;

    localparam logic [31:0]      c_MAX_TAG = 32'(MAX_TAG);
    localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

    state_t           r_state;
    logic             r_drop;
    logic [31:0]      r_tag;
    logic [31:0]      r_meth;
    logic [ERR_W-1:0] r_err;

    logic [95:0]      r_mem [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;

    logic             w_beat_rdy;
    logic             w_accept;
    logic             w_enq;
    logic             w_deq;
    logic             w_tag_bad;

    // Ready is forced low while reset is held so the upstream sees the block
    // as unavailable immediately, not only after the next clock edge.
    // A dropped frame never touches the FIFO, so its last beat is always
    // accepted even when the FIFO is full.
    assign w_beat_rdy = nRST ? 1'b0 :
                        ((r_state != S_V) || (r_count < 2'd2) || r_drop);
    assign w_accept   = bus.beat_enq__ENA && w_beat_rdy;
    assign w_enq      = w_accept && (r_state == S_V) && !r_drop;
    assign w_deq      = (r_count != 2'd0) && bus.pipe_enq__RDY;
    assign w_tag_bad  = (bus.beat_enq_v == 32'd0) || (bus.beat_enq_v > c_MAX_TAG);

    assign bus.beat_enq__RDY = w_beat_rdy;
    assign bus.pipe_enq__ENA = w_deq;
    assign bus.pipe_enq_v    = (r_count != 2'd0) ? r_mem[r_head] : 96'h0;
    assign err_count         = r_err;

    // Frame assembly state machine
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state <= S_TAG;
            r_drop  <= 1'b0;
            r_tag   <= 32'd0;
            r_meth  <= 32'd0;
            r_err   <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_TAG: begin
                    r_tag   <= bus.beat_enq_v;
                    r_drop  <= w_tag_bad;
                    r_state <= S_METH;
                end
                S_METH: begin
                    r_meth  <= bus.beat_enq_v;
                    r_state <= S_V;
                end
                S_V: begin
                    if (r_drop && (r_err != c_ERR_MAX)) begin
                        r_err <= r_err + 1'b1;
                    end
                    r_drop  <= 1'b0;
                    r_state <= S_TAG;
                end
                default: begin
                    r_state <= S_TAG;
                end
            endcase
        end
    end

    // Two-entry output FIFO; simultaneous push and pop keeps the count.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= 96'h0;
            end
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) begin
                r_mem[r_tail] <= {bus.beat_enq_v, r_meth, r_tag};
                r_tail        <= ~r_tail;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_echo_pipe_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_echo_pipe_deserializer
// Description : Self-checking bench for echo_pipe_deserializer. A frame-level
//               reference model (beat position, message queue, error count)
//               predicts the handshake outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_pipe_deserializer;

    localparam int unsigned MAX_TAG = 1;
    localparam int unsigned ERR_W   = 8;
    localparam int unsigned ERR_MAX = (1 << ERR_W) - 1;

    logic             CLK;
    logic             nRST;
    logic [ERR_W-1:0] err_count;

    echo_pipe_deserializer_if u_if ();

    echo_pipe_deserializer #(
        .MAX_TAG (MAX_TAG),
        .ERR_W   (ERR_W)
    ) u_dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (u_if),
        .err_count (err_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int n_deq = 0;

    // Reference model: position within frame, captured fields, pending msgs
    int          m_pos;
    logic        m_drop;
    logic [31:0] m_tag;
    logic [31:0] m_meth;
    logic [95:0] m_q [$];
    int unsigned m_err;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_drop = 1'b0;
        m_tag  = 32'd0;
        m_meth = 32'd0;
        m_q.delete();
        m_err  = 0;
    endtask

    // One clock: drive, predict and check, then advance the model on posedge.
    task automatic cycle(input logic ena, input logic [31:0] v, input logic prdy,
                         output logic acc);
        logic        exp_rdy;
        logic        exp_ena;
        logic [95:0] exp_v;
        u_if.beat_enq__ENA = ena;
        u_if.beat_enq_v    = v;
        u_if.pipe_enq__RDY = prdy;
        #1;
        exp_rdy = (m_pos != 2) || (m_q.size() < 2) || m_drop;
        exp_ena = (m_q.size() != 0) && prdy;
        exp_v   = (m_q.size() != 0) ? m_q[0] : 96'h0;
        chk("beat_rdy", {95'd0, u_if.beat_enq__RDY}, {95'd0, exp_rdy});
        chk("pipe_ena", {95'd0, u_if.pipe_enq__ENA}, {95'd0, exp_ena});
        chk("pipe_v", u_if.pipe_enq_v, exp_v);
        chk("err_count", 96'(err_count), 96'(m_err));
        acc = ena && exp_rdy;
        @(posedge CLK);
        if (exp_ena) begin
            void'(m_q.pop_front());
            n_deq++;
        end
        if (acc) begin
            case (m_pos)
                0: begin
                    m_tag  = v;
                    m_drop = (v == 32'd0) || (v > MAX_TAG);
                end
                1: m_meth = v;
                default: begin
                    if (!m_drop) m_q.push_back({v, m_meth, m_tag});
                    else if (m_err < ERR_MAX) m_err++;
                    m_drop = 1'b0;
                end
            endcase
            m_pos = (m_pos + 1) % 3;
        end
        @(negedge CLK);
    endtask

    // Present one beat until it is accepted, bounded.
    task automatic send_beat(input logic [31:0] v, input logic prdy);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cycle(1'b1, v, prdy, acc);
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_beat_timeout: beat %h not accepted in %0d cycles", v, tries);
        end
    endtask

    task automatic send_frame(input logic [31:0] t, input logic [31:0] m,
                              input logic [31:0] v, input logic prdy);
        send_beat(t, prdy);
        send_beat(m, prdy);
        send_beat(v, prdy);
    endtask

    task automatic idle(input int n, input logic prdy);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, prdy, acc);
    endtask

    function automatic logic [31:0] rand_tag();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd2;
            2:       return $urandom();
            default: return 32'd1;
        endcase
    endfunction

    initial begin
        logic acc;
        int   base;
        u_if.beat_enq__ENA = 1'b0;
        u_if.beat_enq_v    = 32'd0;
        u_if.pipe_enq__RDY = 1'b1;
        nRST = 1'b1;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_beat_rdy", {95'd0, u_if.beat_enq__RDY}, 96'd0);
        chk("rst_pipe_ena", {95'd0, u_if.pipe_enq__ENA}, 96'd0);
        chk("rst_pipe_v", u_if.pipe_enq_v, 96'h0);
        chk("rst_err", 96'(err_count), 96'd0);
        nRST = 1'b0;
        @(negedge CLK);

        // Single valid frame, message visible the next cycle
        send_frame(32'd1, 32'd5, 32'hCAFE_F00D, 1'b1);
        chk("frame1_v", u_if.pipe_enq_v, 96'hCAFEF00D_00000005_00000001);
        idle(2, 1'b1);

        // Downstream stalled: two buffered, third frame blocked in its last beat
        base = n_deq;
        send_frame(32'd1, 32'h11, 32'hA1, 1'b0);
        send_frame(32'd1, 32'h22, 32'hA2, 1'b0);
        send_beat(32'd1, 1'b0);
        send_beat(32'h33, 1'b0);
        cycle(1'b1, 32'hA3, 1'b0, acc);
        chk("full_blocks", {95'd0, acc}, 96'd0);
        send_beat(32'hA3, 1'b1);
        idle(4, 1'b1);
        chk("stall_drain_cnt", 96'(n_deq - base), 96'd3);

        // Bad tags, framing must stay aligned
        send_frame(32'd2, 32'h1, 32'h2, 1'b1);
        send_frame(32'd0, 32'h3, 32'h4, 1'b1);
        send_frame(32'h8000_0001, 32'h5, 32'h6, 1'b1);
        send_frame(32'd1, 32'hBEEF, 32'hF00D, 1'b1);
        chk("after_bad_v", u_if.pipe_enq_v, 96'h0000F00D_0000BEEF_00000001);
        chk("after_bad_err", 96'(err_count), 96'd3);
        idle(2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] b;
            b = (m_pos == 0) ? rand_tag() : $urandom();
            cycle(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 2) != 0), acc);
        end
        idle(4, 1'b1);

        // Error counter saturation
        for (int i = 0; i < 256; i++) send_frame(32'd2, 32'd0, 32'd0, 1'b1);
        chk("err_sat", 96'(err_count), 96'(ERR_MAX));

        // Asynchronous reset mid-frame with one message buffered
        send_frame(32'd1, 32'h77, 32'h88, 1'b0);
        send_beat(32'd1, 1'b0);
        send_beat(32'h99, 1'b0);
        #2 nRST = 1'b1;
        #1;
        chk("arst_beat_rdy", {95'd0, u_if.beat_enq__RDY}, 96'd0);
        chk("arst_pipe_ena", {95'd0, u_if.pipe_enq__ENA}, 96'd0);
        chk("arst_pipe_v", u_if.pipe_enq_v, 96'h0);
        chk("arst_err", 96'(err_count), 96'd0);
        @(negedge CLK);
        nRST = 1'b0;
        model_reset();
        send_frame(32'd1, 32'hA, 32'hB, 1'b1);
        chk("post_rst_v", u_if.pipe_enq_v, 96'h0000000B_0000000A_00000001);
        idle(2, 1'b1);

        // Back-to-back frames at full rate
        base = n_deq;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'd1, 1'b1, acc);
            cycle(1'b1, $urandom(), 1'b1, acc);
            cycle(1'b1, $urandom(), 1'b1, acc);
        end
        idle(2, 1'b1);
        chk("b2b_msgs", 96'(n_deq - base), 96'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
